// File: rtl/k16_mem_arbiter.sv
// rtl/k16_mem_arbiter.sv - video-priority CPU/video arbiter for one synchronous single-port RAM
// Optional CPU starvation guard: define K16_ARB_STARVE_GUARD_EN.
module k16_mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_write,
  output logic              cpu_gnt,
  output logic              cpu_hold,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("k16_mem_arbiter: MAX_WAIT must be in 1..255");
  end

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [1:0]        tag_q, tag_d;
  logic              cpu_rv_q, cpu_rv_d;
  logic              vid_rv_q, vid_rv_d;
  logic              cpu_acc, vid_acc, cpu_force;

`ifdef K16_ARB_STARVE_GUARD_EN
  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);
  logic [7:0] wait_q, wait_d;

  assign cpu_force = cpu_req && (wait_q == MAX_WAIT_C);

  always_comb begin
    wait_d = wait_q;
    if (!cpu_req || cpu_acc) begin
      wait_d = 8'd0;
    end else if (wait_q != MAX_WAIT_C) begin
      wait_d = wait_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) wait_q <= 8'd0;
    else       wait_q <= wait_d;
  end
`else
  assign cpu_force = 1'b0;
`endif

  // Video wins ties so scanout never misses a fetch; reset blocks all grants.
  always_comb begin
    cpu_gnt = 1'b0;
    vid_gnt = 1'b0;
    if (!reset) begin
      if (vid_req && !cpu_force) vid_gnt = 1'b1;
      else if (cpu_req)          cpu_gnt = 1'b1;
    end
  end

  assign cpu_acc  = cpu_req & cpu_gnt;
  assign vid_acc  = vid_req & vid_gnt;
  assign cpu_hold = cpu_req & ~cpu_gnt;

  always_comb begin
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    tag_d    = {cpu_acc & ~cpu_write, vid_acc};
    cpu_rv_d = tag_q[1];
    vid_rv_d = tag_q[0];
    if (cpu_acc) begin
      addr_d  = cpu_addr;
      wdata_d = cpu_wdata;
      we_d    = cpu_write;
    end else if (vid_acc) begin
      addr_d  = vid_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      tag_q    <= 2'b00;
      cpu_rv_q <= 1'b0;
      vid_rv_q <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      tag_q    <= tag_d;
      cpu_rv_q <= cpu_rv_d;
      vid_rv_q <= vid_rv_d;
    end
  end

  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_we     = we_q;
  assign cpu_rvalid = cpu_rv_q;
  assign vid_rvalid = vid_rv_q;
  assign cpu_rdata  = mem_rdata;
  assign vid_rdata  = mem_rdata;

endmodule

// File: doc/k16_mem_arbiter.md
Name: k16_mem_arbiter

Overview:
- Shares one synchronous single-port RAM between the K16 CPU bus and the VGA pixel-fetch engine.
- Video has priority so scanout never misses data; the CPU is stalled through cpu_hold while it waits.
- The block has a registered memory-side pipeline and a read-return tag pipe that routes each read result back to the requester that issued it.

Parameters:
- ADDR_W, 16, address width of the RAM and of both requesters.
- DATA_W, 16, data word width.
- MAX_WAIT, 8, number of consecutive denied CPU cycles before the CPU is forced through (used only with the optional feature); legal range 1..255.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request; level, held until granted
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_write  in  1  1 = write, 0 = read
- cpu_gnt  out  1  combinational ready; the access transfers at the edge where cpu_req & cpu_gnt
- cpu_hold  out  1  cpu_req & ~cpu_gnt; drives the CPU hold input
- cpu_rdata  out  DATA_W  read data, equal to mem_rdata
- cpu_rvalid  out  1  registered; high in the cycle cpu_rdata holds a CPU read result
- vid_req  in  1  video read request (video never writes)
- vid_addr  in  ADDR_W  video address
- vid_gnt  out  1  combinational ready for video
- vid_rdata  out  DATA_W  equal to mem_rdata
- vid_rvalid  out  1  registered; video read result valid
- mem_addr  out  ADDR_W  registered RAM address
- mem_wdata  out  DATA_W  registered RAM write data
- mem_we  out  1  registered RAM write enable, one cycle per write
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_addr is presented

Behaviour:
- Reset values:
  - mem_addr = 0, mem_wdata = 0, mem_we = 0.
  - cpu_rvalid = 0, vid_rvalid = 0.
  - Tag pipe cleared; wait counter = 0.
  - cpu_gnt and vid_gnt are forced to 0 while reset is high.
- Grant rule, evaluated every cycle:
  - Only vid_req: vid_gnt = 1.
  - Only cpu_req: cpu_gnt = 1.
  - Both asserted: video wins, unless the starvation override applies (see Optional Feature).
  - At most one grant is high per cycle.
- Accept edge E0 (req & gnt):
  - The winner's address and data are registered onto mem_* at E0.
  - mem_we = cpu_write for a CPU access, 0 for video.
  - A 2-bit read tag is registered at the same edge: {cpu_read, vid_read}.
- Read latency:
  - The RAM samples mem_addr at E1; mem_rdata is valid after E1.
  - The matching rvalid is high from E1 to E2, so the requester samples data at E2.
  - Accept-to-data is 2 edges, fully pipelined: one new access per cycle, back-to-back.
- Writes: mem_we is high for exactly the one cycle after E0; no rvalid is produced.
- Idle cycle (no grant): mem_we = 0; mem_addr and mem_wdata hold their previous values; a 0 tag is shifted into the pipe.
- Request rules: requesters keep req, addr, wdata and write stable until granted. Dropping req before it is granted withdraws the request, with no side effects.
- Reset mid-operation:
  - In-flight tags are discarded; no rvalid is asserted afterwards.
  - A write accepted in the same cycle reset is sampled is lost (mem_we = 0 after that edge).
- No internal queueing: the block holds no more than one access per pipeline stage, so no full/empty conditions exist.

Optional Feature:
- Macro: K16_ARB_STARVE_GUARD_EN.
- Defined:
  - An 8-bit wait counter increments on each cycle where cpu_req = 1 and cpu_gnt = 0, saturating at MAX_WAIT.
  - When the counter equals MAX_WAIT, the CPU wins the next arbitration even if vid_req = 1.
  - The counter clears to 0 on any CPU accept and whenever cpu_req = 0.
- Not defined:
  - Strict video priority; the CPU may starve indefinitely.
  - The counter logic is absent, and MAX_WAIT is unused.

Test Plan:
- Single CPU read: cpu_req = 1, cpu_addr = 0x0010, RAM[0x0010] = 0xBEEF, vid_req = 0. Expect cpu_gnt = 1 in the same cycle, mem_addr = 0x0010 after E0, cpu_rvalid = 1 with cpu_rdata = 0xBEEF after E1, and cpu_hold = 0 throughout.
- CPU write then read-back: write 0x1234 to 0x0020 followed immediately by a read of 0x0020. Expect mem_we = 1 for one cycle with mem_wdata = 0x1234, then cpu_rvalid with 0x1234 two edges after the read accept.
- Contention: cpu_req and vid_req both high for 3 cycles (vid_addr 0x8000..0x8002). Expect vid_gnt on all 3 cycles, cpu_hold = 1, and the CPU granted on cycle 4. Expect vid_rvalid data matches RAM[0x8000..0x8002] in order.
- Starvation guard (macro defined, MAX_WAIT = 4): vid_req held high continuously, cpu_req high. Expect the CPU granted on the 5th request cycle and the counter back to 0. With the macro undefined, expect no CPU grant for 20 cycles.
- Reset mid-read: accept a video read, then assert reset in the next cycle. Expect vid_rvalid to stay 0 and all mem_* outputs equal 0 after the reset edge.
- Back-to-back interleave: alternate CPU read and video read each cycle for 6 cycles. Expect rvalid to follow the same interleave exactly 2 edges later, with each requester receiving its own addresses' data.
